// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback stage and its load-use scoreboard.
package wb_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_LSU,
        WB_ALU_HOLD,
        WB_ALU
    } wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Load-use scoreboard: one busy bit per architectural register, x0 never busy.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  reg_addr_t           look_rs1,
    input  reg_addr_t           look_rs2,
    input  reg_addr_t           look_rd,
    output logic                hit_rs1,
    output logic                hit_rs2,
    output logic                hit_rd,
    output logic [NUM_REGS-1:0] busy
);
    logic [NUM_REGS-1:0] busy_q;

    // Set is applied after clear so a same-edge collision keeps the new load pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            if (clr_en)
                busy_q[clr_addr] <= 1'b0;
            if (set_en)
                busy_q[set_addr] <= 1'b1;
            busy_q[0] <= 1'b0;
        end
    end

    assign hit_rs1 = (look_rs1 != '0) && busy_q[look_rs1];
    assign hit_rs2 = (look_rs2 != '0) && busy_q[look_rs2];
    assign hit_rd  = (look_rd  != '0) && busy_q[look_rd];
    assign busy    = busy_q;
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: LSU/ALU arbitration onto one registered register-file write port,
// plus load-use stall. Optional stall counter enabled by WB_STALL_CNT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_issue_valid,
    input  logic [4:0]      i_issue_rs1,
    input  logic [4:0]      i_issue_rs2,
    input  logic [4:0]      i_issue_rd,
    input  logic            i_issue_rd_wren,
    input  logic            i_issue_is_load,
    output logic            o_issue_stall,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_lsu_valid,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren,
    output logic [31:0]     o_busy
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]     o_stall_cnt
`endif
);
    logic hit_rs1, hit_rs2, hit_rd;
    logic issue_accept, sb_set, sb_clr;
    logic alu_accept;

    logic            hold_vld;
    reg_addr_t       hold_rd;
    logic [XLEN-1:0] hold_data;

    wb_src_e         sel_src;
    reg_addr_t       sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            vld_p1;
    wb_src_e         src_p1;
    reg_addr_t       addr_p1;
    logic [XLEN-1:0] data_p1;

    assign o_issue_stall = i_issue_valid &
                           (hit_rs1 | hit_rs2 | (i_issue_rd_wren & hit_rd));
    assign issue_accept  = i_issue_valid & ~o_issue_stall;
    assign sb_set        = issue_accept & i_issue_is_load & i_issue_rd_wren &
                           (i_issue_rd != '0);
    // Clear only once the load data is actually visible in the register file.
    assign sb_clr        = vld_p1 & (src_p1 == WB_LSU);

    wb_scoreboard u_scoreboard (
        .clk      (i_clk),
        .rst      (i_reset),
        .set_en   (sb_set),
        .set_addr (i_issue_rd),
        .clr_en   (sb_clr),
        .clr_addr (addr_p1),
        .look_rs1 (i_issue_rs1),
        .look_rs2 (i_issue_rs2),
        .look_rd  (i_issue_rd),
        .hit_rs1  (hit_rs1),
        .hit_rs2  (hit_rs2),
        .hit_rd   (hit_rd),
        .busy     (o_busy)
    );

    assign o_alu_ready = ~hold_vld & ~i_reset;
    assign alu_accept  = i_alu_valid & o_alu_ready;

    // p0: source select, LSU > held ALU > new ALU
    always_comb begin
        sel_src  = WB_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (i_lsu_valid) begin
            sel_src  = WB_LSU;
            sel_rd   = i_lsu_rd;
            sel_data = i_lsu_data;
        end else if (hold_vld) begin
            sel_src  = WB_ALU_HOLD;
            sel_rd   = hold_rd;
            sel_data = hold_data;
        end else if (alu_accept) begin
            sel_src  = WB_ALU;
            sel_rd   = i_alu_rd;
            sel_data = i_alu_data;
        end
    end

    // p1: registered write port; writes to x0 are consumed without a write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1   <= 1'b0;
            src_p1   <= WB_NONE;
            addr_p1  <= '0;
            data_p1  <= '0;
            hold_vld <= 1'b0;
        end else begin
            if (sel_src != WB_NONE && sel_rd != '0) begin
                vld_p1  <= 1'b1;
                src_p1  <= sel_src;
                addr_p1 <= sel_rd;
                data_p1 <= sel_data;
            end else begin
                vld_p1 <= 1'b0;
                src_p1 <= WB_NONE;
            end
            if (i_lsu_valid && alu_accept)
                hold_vld <= 1'b1;
            else if (sel_src == WB_ALU_HOLD)
                hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_lsu_valid && alu_accept) begin
            hold_rd   <= i_alu_rd;
            hold_data <= i_alu_data;
        end
    end

    assign o_rd_wren = vld_p1;
    assign o_rd_addr = addr_p1;
    assign o_rd_data = data_p1;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            stall_cnt <= '0;
        else if (o_issue_stall)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign o_stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps then random traffic against a queue-based reference model.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_rd_wren, issue_is_load;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        o_issue_stall, o_alu_ready, o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data, o_busy;
`ifdef WB_STALL_CNT_EN
    logic [31:0] o_stall_cnt;
`endif

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_issue_valid   (issue_valid),
        .i_issue_rs1     (issue_rs1),
        .i_issue_rs2     (issue_rs2),
        .i_issue_rd      (issue_rd),
        .i_issue_rd_wren (issue_rd_wren),
        .i_issue_is_load (issue_is_load),
        .o_issue_stall   (o_issue_stall),
        .i_alu_valid     (alu_valid),
        .i_alu_rd        (alu_rd),
        .i_alu_data      (alu_data),
        .o_alu_ready     (o_alu_ready),
        .i_lsu_valid     (lsu_valid),
        .i_lsu_rd        (lsu_rd),
        .i_lsu_data      (lsu_data),
        .o_rd_addr       (o_rd_addr),
        .o_rd_data       (o_rd_data),
        .o_rd_wren       (o_rd_wren),
        .o_busy          (o_busy)
`ifdef WB_STALL_CNT_EN
        ,
        .o_stall_cnt     (o_stall_cnt)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int          vectors = 0;
    int          errs    = 0;
    int          ncmp    = 0;
    bit [31:0]   m_busy;
    bit          m_wren, m_commit_lsu, m_known;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_cnt;
    ent_t        aq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit mhit(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r];
    endfunction

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_rd_wren = 0; issue_is_load = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input bit wren, input bit ld);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_rd_wren = wren; issue_is_load = ld;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit          st, rdy, pick, is_lsu;
        logic [4:0]  prd;
        logic [31:0] pd;
        ent_t        e;
        #1;
        st  = issue_valid && (mhit(issue_rs1) || mhit(issue_rs2) ||
                              (issue_rd_wren && mhit(issue_rd)));
        rdy = (aq.size() == 0) && !reset;
        chk("issue_stall", {31'd0, o_issue_stall}, {31'd0, st});
        chk("alu_ready", {31'd0, o_alu_ready}, {31'd0, rdy});
        if (reset) begin
            m_busy = 0; m_wren = 0; m_commit_lsu = 0; m_known = 1;
            m_addr = 0; m_data = 0; m_cnt = 0;
            aq.delete();
        end else begin
            if (m_wren && m_commit_lsu) m_busy[m_addr] = 1'b0;
            if (issue_valid && !st && issue_is_load && issue_rd_wren && issue_rd != 0)
                m_busy[issue_rd] = 1'b1;
            if (alu_valid && rdy) aq.push_back('{alu_rd, alu_data});
            pick = 0; is_lsu = 0; prd = 0; pd = 0;
            if (lsu_valid) begin
                pick = 1; is_lsu = 1; prd = lsu_rd; pd = lsu_data;
            end else if (aq.size() > 0) begin
                e = aq.pop_front();
                pick = 1; prd = e.rd; pd = e.data;
            end
            if (pick && prd != 0) begin
                m_wren = 1; m_addr = prd; m_data = pd; m_known = 1; m_commit_lsu = is_lsu;
            end else begin
                m_wren = 0; m_commit_lsu = 0;
                if (pick) m_known = 0;
            end
            m_cnt = m_cnt + {31'd0, st};
        end
        @(posedge clk);
        #1;
        vectors++;
        chk("rd_wren", {31'd0, o_rd_wren}, {31'd0, m_wren});
        chk("busy", o_busy, m_busy);
        if (m_known) begin
            chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, m_addr});
            chk("rd_data", o_rd_data, m_data);
        end
`ifdef WB_STALL_CNT_EN
        chk("stall_cnt", o_stall_cnt, m_cnt);
`endif
    endtask

    initial begin
        idle();
        m_busy = 0; m_wren = 0; m_commit_lsu = 0; m_known = 0;
        m_addr = 0; m_data = 0; m_cnt = 0;
        reset = 1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 0;

        cycle();
        chk("idle_busy", o_busy, 32'd0);
        chk("idle_wren", {31'd0, o_rd_wren}, 32'd0);

        // load x5 then a consumer of x5
        issue(5'd0, 5'd0, 5'd5, 1, 1);
        cycle();
        chk("load5_busy", {31'd0, o_busy[5]}, 32'd1);
        issue(5'd5, 5'd0, 5'd0, 0, 0);
        cycle();
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hDEADBEEF;
        cycle();
        chk("lsu5_wren", {31'd0, o_rd_wren}, 32'd1);
        chk("lsu5_addr", {27'd0, o_rd_addr}, 32'd5);
        chk("lsu5_data", o_rd_data, 32'hDEADBEEF);
        lsu_valid = 0;
        cycle();
        chk("busy5_clear", {31'd0, o_busy[5]}, 32'd0);
        cycle();
        idle();

        // ALU and LSU collide
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
        cycle();
        chk("collide_lsu_addr", {27'd0, o_rd_addr}, 32'd4);
        chk("collide_lsu_data", o_rd_data, 32'h22);
        idle();
        cycle();
        chk("collide_alu_addr", {27'd0, o_rd_addr}, 32'd3);
        chk("collide_alu_data", o_rd_data, 32'h11);
        cycle();

        // load to x0
        issue(5'd0, 5'd0, 5'd0, 1, 1);
        cycle();
        chk("load0_busy", o_busy, 32'd0);
        idle();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h5555AAAA;
        cycle();
        chk("lsu0_wren", {31'd0, o_rd_wren}, 32'd0);
        idle();

        // WAW on x7
        issue(5'd0, 5'd0, 5'd7, 1, 1);
        cycle();
        issue(5'd1, 5'd2, 5'd7, 1, 0);
        cycle();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
        cycle();
        lsu_valid = 0;
        cycle();
        chk("waw_clear", {31'd0, o_busy[7]}, 32'd0);
        cycle();
        idle();

        // reset with x9 pending and hold full
        issue(5'd0, 5'd0, 5'd9, 1, 1);
        cycle();
        idle();
        alu_valid = 1; alu_rd = 2; alu_data = 32'hABCD;
        lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h1234;
        cycle();
        idle();
        reset = 1;
        cycle();
        chk("rst_busy", o_busy, 32'd0);
        chk("rst_wren", {31'd0, o_rd_wren}, 32'd0);
        reset = 0;
        cycle();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            issue_valid   = $urandom_range(0, 1);
            issue_rs1     = 5'($urandom_range(0, 7));
            issue_rs2     = 5'($urandom_range(0, 7));
            issue_rd      = 5'($urandom_range(0, 7));
            issue_rd_wren = ($urandom_range(0, 3) != 0);
            issue_is_load = $urandom_range(0, 1);
            alu_valid     = $urandom_range(0, 1);
            alu_rd        = 5'($urandom_range(0, 7));
            alu_data      = $urandom;
            lsu_valid     = ($urandom_range(0, 2) == 0);
            lsu_rd        = 5'($urandom_range(0, 7));
            lsu_data      = $urandom;
            cycle();
        end
        reset = 0;
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage that owns the single write port of the integer register file. Arbitrates a single-cycle ALU result stream and a variable-latency LSU load stream onto one registered write port. Keeps a load-use scoreboard that stalls issue while a source or destination register awaits load data. Sits between execute/LSU and the register file; the stall output feeds decode.

## Interface

Parameters:
- XLEN, 32, data width of results and write port.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_issue_valid  in  1  decode presents an instruction this cycle.
- i_issue_rs1  in  5  source register 1 of the issuing instruction.
- i_issue_rs2  in  5  source register 2.
- i_issue_rd  in  5  destination register.
- i_issue_rd_wren  in  1  instruction writes rd.
- i_issue_is_load  in  1  instruction is a load (result arrives via LSU).
- o_issue_stall  out  1  hold issue; instruction is not accepted this cycle.
- i_alu_valid  in  1  ALU result valid.
- i_alu_rd  in  5  ALU destination.
- i_alu_data  in  XLEN  ALU result.
- o_alu_ready  out  1  ALU result accepted when valid and ready both high.
- i_lsu_valid  in  1  load data valid; always accepted, no backpressure.
- i_lsu_rd  in  5  load destination.
- i_lsu_data  in  XLEN  load data.
- o_rd_addr  out  5  register file write address (registered).
- o_rd_data  out  XLEN  register file write data (registered).
- o_rd_wren  out  1  register file write enable (registered).
- o_busy  out  32  scoreboard vector; bit n set = load pending for xn.

## Operation

- Scoreboard busy[31:0]; busy[0] is constant 0.
- Issue accepted = i_issue_valid & !o_issue_stall.
- Accepted issue with is_load & rd_wren & rd!=0 sets busy[rd].
- o_issue_stall = i_issue_valid & (hit(rs1) | hit(rs2) | (rd_wren & hit(rd))). hit(r) = r!=0 & busy[r]. Stall is computed from registered busy only.
- Busy clears on the edge where the registered write port commits an LSU write (o_rd_wren=1 with internal src=LSU). This is one cycle after LSU acceptance, so a read after the clear sees the updated register file.
- Set and clear on the same edge target different registers (WAW stall guarantees this); both apply.
- ALU hold buffer: 1 entry. o_alu_ready = !hold_valid & !i_reset.
- Write-port priority each cycle: LSU > hold buffer > new ALU.
- ALU accepted while LSU valid: ALU result goes into hold and the LSU result goes to the port.
- Hold drains in the first cycle with no LSU valid.
- Selected write with rd=0: consumed, o_rd_wren=0; busy is unaffected.
- No source valid: o_rd_wren=0; o_rd_addr and o_rd_data keep their previous values.

## Timing

- Reset values: o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_busy=0, hold empty, o_alu_ready=0 during reset and 1 in the first cycle after.
- Reset mid-operation discards pending loads and any held ALU result. LSU data arriving after reset is still written but cannot underflow the scoreboard: clearing a 0 bit is a no-op.
- Latency, LSU valid to o_rd_wren: 1 cycle. LSU valid to busy clear: 2 edges.
- Latency, ALU accept to o_rd_wren: 1 cycle if no LSU that cycle; otherwise 1 + the number of consecutive LSU cycles.
- o_issue_stall and o_alu_ready are combinational; all other outputs are registered.

## Configuration

- WB_STALL_CNT_EN defined:
  - Adds output o_stall_cnt [31:0], which increments every cycle o_issue_stall=1.
  - Reset to 0; wraps at 2^32.
- WB_STALL_CNT_EN undefined: the port and counter are absent.

## Structure

- Shared package wb_pkg:
  - XLEN_DEF=32, REG_ADDR_W=5, NUM_REGS=32.
  - typedef reg_addr_t.
  - typedef wb_src_e {WB_NONE, WB_LSU, WB_ALU_HOLD, WB_ALU}.
- Sub-module wb_scoreboard: busy vector with set and clear ports, plus the hit logic for three lookups. The arbiter and hold buffer live in the top module.

## Test plan

- Reset, then idle: o_busy=0, o_rd_wren=0, o_alu_ready=1, o_issue_stall=0.
- Issue load rd=5, then issue rs1=5: stall=1; LSU rd=5 data=0xDEADBEEF → next cycle o_rd_wren=1, addr=5, data=0xDEADBEEF; busy[5] clears on the following edge; stall drops.
- ALU rd=3 data=0x11 and LSU rd=4 data=0x22 in the same cycle → cycle+1 writes x4=0x22, cycle+2 writes x3=0x11; o_alu_ready=0 during cycle+1.
- Load to rd=0 issued: busy stays 0, no stall; LSU rd=0 → o_rd_wren stays 0.
- Issue load rd=7, then issue non-load writing rd=7: WAW stall=1 until busy[7] clears.
- Reset asserted with busy[9]=1 and hold full → next cycle busy=0, hold empty, o_rd_wren=0; with WB_STALL_CNT_EN, the counter is 0 and then counts exactly the stall cycles.
